seq_gen: RTL
============

// Module: seq_gen
// PURPOSE
//   Serial bit-sequence generator: transmit-side counterpart of seq_ctr.
//   Latches a WIDTH-bit pattern and a repeat count on a start request, then
//   shifts the pattern out MSB-first on opt, one bit per clk, repeat times.
//   Drives seq_ctr's ip input in loopback benches and stimulus paths.
// PARAMETERS
//   WIDTH  4  pattern length in bits (>=2)
//   CNT_W  4  width of repeat count; max repetitions = 2**CNT_W-1
// PORTS
//   clk      in   1      single clock, all state updates on posedge
//   rst      in   1      synchronous reset, active-high
//   start    in   1      request; sampled only when busy=0
//   pattern  in   WIDTH  bit pattern, latched on accepted start
//   count    in   CNT_W  repetitions, latched on accepted start
//   opt      out  1      serial data, MSB of pattern first
//   valid    out  1      opt carries a pattern bit this cycle
//   busy     out  1      transfer in progress; start ignored
//   done     out  1      one-cycle pulse after final bit
// BEHAVIOUR
//   - All outputs registered. Reset (rst=1 at posedge): opt=0, valid=0,
//     busy=0, done=0, state=IDLE, shift reg/counters cleared. rst wins over
//     every other input, including mid-transfer (transfer aborted, no done).
//   - States: IDLE, SHIFT, GAP (GAP only with SEQ_GEN_GAP_EN), DONE.
//   - IDLE: start=1, count!=0 at edge k -> latch pattern/count; after edge k:
//     state=SHIFT, busy=1, valid=1, opt=pattern[WIDTH-1]. Zero-latency start.
//   - IDLE: start=1, count=0 -> after edge: DONE (done=1, valid=0, busy=1),
//     then IDLE. No bits emitted.
//   - SHIFT: each edge advances one bit; bit index WIDTH-1 down to 0. After
//     bit 0 of a non-final repetition: reload latched pattern, decrement
//     remaining count, continue (no idle cycle without the macro).
//   - After bit 0 of the final repetition: state=DONE for exactly one cycle:
//     done=1, valid=0, opt=0, busy=1. Next edge -> IDLE, done=0, busy=0.
//   - busy=1 in SHIFT/GAP/DONE. start while busy=1 ignored, not queued;
//     pattern/count changes while busy have no effect.
//   - start=1 in the first IDLE cycle after DONE is accepted normally.
//   - opt=0 whenever valid=0.
//   - Total busy cycles = count*WIDTH + 1 (+ count-1 with gap feature).
//   - Remaining-count decrement never wraps; count is unsigned.
// CONFIGURATION
//   SEQ_GEN_GAP_EN defined: after each non-final repetition insert one GAP
//     cycle: valid=0, opt=0, busy=1; then reload and resume SHIFT.
//   SEQ_GEN_GAP_EN undefined: GAP state absent; repetitions back-to-back.
// TESTING
//   1 pattern=4'b1011,count=1,start 1 cycle -> opt/valid=1,0,1,1 over 4
//     cycles, then done=1 one cycle, busy=1 for 5 cycles total.
//   2 pattern=4'b1011,count=2 -> opt 1,0,1,1,1,0,1,1 with valid continuous;
//     with SEQ_GEN_GAP_EN: 1,0,1,1,gap(valid=0),1,0,1,1; done after last bit.
//   3 count=0,start=1 -> valid never asserts; done=1 on the cycle after
//     start; busy=1 for exactly that cycle.
//   4 start=1 with pattern=4'b0110 on cycle 2 of a 4'b1011 transfer -> ignored;
//     output stays 1,0,1,1; single done pulse.
//   5 rst=1 during bit 2 of a transfer -> next cycle opt=0,valid=0,busy=0,
//     done=0; a subsequent start transmits a fresh sequence correctly.
//   6 start held high continuously, count=1 -> transfers repeat each
//     WIDTH+2 cycles (SHIFT x4, DONE, IDLE accept), bits 1,0,1,1 each time.

Source files
------------

// File: rtl/seq_gen.sv
// Serial bit-sequence generator: latches a pattern and repeat count on start,
// then shifts the pattern out MSB-first on opt, count times.
//
// Ports:
//   clk            clock, all state updates on posedge
//   rst            synchronous reset, active-high
//   start          transfer request, sampled only while idle
//   pattern[W-1:0] bit pattern, latched on an accepted start
//   count[C-1:0]   number of repetitions, latched on an accepted start
//   opt            serial data, MSB of the pattern first (0 when valid=0)
//   valid          opt carries a pattern bit this cycle
//   busy           transfer in progress, start ignored
//   done           one-cycle pulse after the final bit
//
// Build option: define SEQ_GEN_GAP_EN to insert one idle GAP cycle
// (valid=0, busy=1) between consecutive repetitions.
module seq_gen #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] count,
  output logic             opt,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

`ifdef SEQ_GEN_GAP_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd3
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             opt_d, valid_d, busy_d, done_d;

  // sh_q holds the bits still to be sent, left-aligned; the bit
  // currently on opt has already been shifted out of it.
  // idx_q counts bits of the current repetition still to follow.
  // rem_q counts repetitions including the one being sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      sh_q    <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      opt     <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sh_q    <= sh_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      opt     <= opt_d;
      valid   <= valid_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    sh_d    = sh_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    opt_d   = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (count != '0) begin
            // First bit goes out on the accepting edge.
            pat_d   = pattern;
            rem_d   = count;
            sh_d    = {pattern[WIDTH-2:0], 1'b0};
            idx_d   = LAST_IDX;
            opt_d   = pattern[WIDTH-1];
            valid_d = 1'b1;
            state_d = SHIFT;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      SHIFT: begin
        busy_d = 1'b1;
        if (idx_q != '0) begin
          opt_d   = sh_q[WIDTH-1];
          valid_d = 1'b1;
          sh_d    = {sh_q[WIDTH-2:0], 1'b0};
          idx_d   = idx_q - 1'b1;
        end else if (rem_q > ONE) begin
          // Guarded by rem_q > 1, so the decrement cannot wrap.
          rem_d = rem_q - ONE;
`ifdef SEQ_GEN_GAP_EN
          state_d = GAP;
`else
          opt_d   = pat_q[WIDTH-1];
          valid_d = 1'b1;
          sh_d    = {pat_q[WIDTH-2:0], 1'b0};
          idx_d   = LAST_IDX;
`endif
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

`ifdef SEQ_GEN_GAP_EN
      GAP: begin
        busy_d  = 1'b1;
        opt_d   = pat_q[WIDTH-1];
        valid_d = 1'b1;
        sh_d    = {pat_q[WIDTH-2:0], 1'b0};
        idx_d   = LAST_IDX;
        state_d = SHIFT;
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
